fifo_access_ctrl: RTL and testbench
===================================

Name: fifo_access_ctrl

Overview:
- Pointer, flag and access controller for the 32x12 FIFO read-memory.
- Generates wraddr, rdaddr, write_en, read_en, fifofull and notempty for that memory.
- Arbitrates push/pop requesters so at most one memory access happens per cycle; the memory drops a read issued alongside a write.
- Reports occupancy, almost flags, read-data-valid and sticky error status to the surrounding datapath.

Parameters:
- ADDRBIT, 5, address width of the memory; FIFO_DEPTH must equal 2**ADDRBIT.
- FIFO_DEPTH, 32, number of entries.
- AFULL_THRESH, 28, almost_full asserts when count >= this value.
- AEMPTY_THRESH, 4, almost_empty asserts when count <= this value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_en  in  1  enable; when low, no grants are issued and all state holds.
- flush  in  1  synchronous clear of pointers, count and rd_valid.
- push_req  in  1  producer wants to write; held until push_ack.
- pop_req  in  1  consumer wants to read; held until pop_ack.
- clr_err  in  1  clears the sticky error flags.
- push_ack  out  1  push granted this cycle; equal to write_en.
- pop_ack  out  1  pop granted this cycle; equal to read_en.
- write_en  out  1  to memory.
- read_en  out  1  to memory.
- wraddr  out  ADDRBIT  current write pointer.
- rdaddr  out  ADDRBIT  current read pointer.
- fifofull  out  1  count == FIFO_DEPTH.
- notempty  out  1  count != 0.
- count  out  ADDRBIT+1  occupancy, range 0..FIFO_DEPTH.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- rd_valid  out  1  memory read_data holds the popped word; high for the cycle after pop_ack.
- overflow  out  1  sticky: push_req seen while full.
- underflow  out  1  sticky: pop_req seen while empty.

Behaviour:
- Reset (rst=1, asynchronous): wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, overflow=0, underflow=0, last_grant=RD.
  - Derived outputs after reset: fifofull=0, notempty=0, almost_empty=1, almost_full=0.
  - Reset mid-operation aborts any pending grant immediately.
- Grant logic is combinational from registered state and the current requests; addresses and flags are registered-state derived.
  - push_legal = fifo_en & push_req & !fifofull & !flush.
  - pop_legal = fifo_en & pop_req & notempty & !flush.
  - Only one legal: grant it.
  - Both legal: round-robin on last_grant. last_grant=RD grants the write; last_grant=WR grants the read. last_grant updates on each grant.
  - The loser is not errored and retries next cycle.
- Write grant: write_en=1 with wraddr=wr_ptr. At the edge, the memory stores the word, wr_ptr+1 (wraps 31->0), count+1.
- Read grant: read_en=1 with rdaddr=rd_ptr. At the edge, the memory latches the word, rd_ptr+1 (wraps), count-1, and rd_valid=1 for exactly the next cycle.
- Latency: pop_ack in cycle N gives rd_valid and valid data in cycle N+1. Back-to-back pops give continuous rd_valid.
- Full: push is never granted; pop_req alone or together with push_req is granted as a pop.
- Empty: pop is never granted; push is granted.
- Errors: overflow is set at the edge when fifo_en & push_req & fifofull; underflow is set when fifo_en & pop_req & !notempty.
  - clr_err clears both flags.
  - If a set and clr_err occur in the same cycle, the set wins.
- flush (with fifo_en either value): at the edge, pointers=0, count=0, rd_valid=0.
  - No acks are issued in the flush cycle; error flags and last_grant are unchanged.
- fifo_en=0: acks=0, no pointer or count change, no error setting, rd_valid cleared next edge. Memory contents are untouched.
- count never wraps; the internal assertion is 0 <= count <= FIFO_DEPTH and count == (wr_ptr - rd_ptr) mod DEPTH, except count == DEPTH when the pointers are equal and the FIFO is full.

Decomposition:
- Package fifo_ctrl_pkg holds:
  - typedef enum grant_e {GNT_NONE, GNT_WR, GNT_RD};
  - default constants for ADDRBIT, FIFO_DEPTH and the thresholds.
- One sub-module, rr_arb2: a 2-requester round-robin arbiter holding last_grant, with req[1:0] in and gnt[1:0] out.
- Pointers, count, flags and errors stay in fifo_access_ctrl.

Test Plan:
- Reset, then 32 consecutive push_req with fifo_en=1 -> 32 push_acks, wraddr 0..31, count=32, fifofull=1, almost_full from count=28; a 33rd push sets overflow=1 with no write_en.
- Full FIFO with push_req=pop_req=1 -> pop_ack only, count=31; next cycle both are legal and push_ack follows (alternating grants).
- Empty, pop_req=1 -> no read_en, underflow=1; clr_err then drops underflow to 0; clr_err together with a new pop on empty keeps underflow=1.
- Push 3, then pop 3 back-to-back -> rdaddr 0,1,2; rd_valid high for the 3 cycles after each pop_ack; notempty falls after the third pop.
- Wrap: 40 push/pop pairs interleaved -> pointers wrap 31->0; count stays in 0..1; no errors raised.
- Count=10, flush=1 with push_req=1 -> no ack, count=0, pointers=0; assert rst mid-pop -> rd_valid=0 immediately.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - shared types and default sizing for the FIFO access controller
// Purpose: grant encoding used by the arbiter plus the default memory geometry
// and occupancy thresholds for the 32x12 FIFO read-memory.
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WR,
        GNT_RD
    } grant_e;

    localparam int DEF_ADDRBIT       = 5;
    localparam int DEF_FIFO_DEPTH    = 32;
    localparam int DEF_AFULL_THRESH  = 28;
    localparam int DEF_AEMPTY_THRESH = 4;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter for memory write/read access
// Purpose: grants at most one of two requesters per cycle, alternating on conflict.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   req[1:0]  bit 0 = write requester, bit 1 = read requester
//   gnt[1:0]  one-hot grant, same bit mapping as req (combinational)
module rr_arb2
    import fifo_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    grant_e last_grant;

    // On a conflict the side that did not win last time gets the slot.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == GNT_WR) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GNT_RD;
        end else if (gnt[0]) begin
            last_grant <= GNT_WR;
        end else if (gnt[1]) begin
            last_grant <= GNT_RD;
        end
    end

endmodule

// File: rtl/fifo_access_ctrl.sv
// rtl/fifo_access_ctrl.sv - pointer, flag and access controller for the FIFO read-memory
// Purpose: arbitrates push/pop requests into one memory access per cycle and
// keeps pointers, occupancy, almost flags, read-valid and sticky errors.
// Ports:
//   clk, rst                clock and asynchronous active-high reset
//   fifo_en, flush          global enable and synchronous clear
//   push_req, pop_req       held requests, answered by push_ack / pop_ack
//   clr_err                 clears overflow / underflow
//   write_en, read_en       memory strobes (identical to the acks)
//   wraddr, rdaddr          memory addresses (current pointers)
//   fifofull, notempty      memory-side flags
//   count, almost_full, almost_empty, rd_valid, overflow, underflow  status
module fifo_access_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDRBIT       = DEF_ADDRBIT,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fifo_en,
    input  logic               flush,
    input  logic               push_req,
    input  logic               pop_req,
    input  logic               clr_err,
    output logic               push_ack,
    output logic               pop_ack,
    output logic               write_en,
    output logic               read_en,
    output logic [ADDRBIT-1:0] wraddr,
    output logic [ADDRBIT-1:0] rdaddr,
    output logic               fifofull,
    output logic               notempty,
    output logic [ADDRBIT:0]   count,
    output logic               almost_full,
    output logic               almost_empty,
    output logic               rd_valid,
    output logic               overflow,
    output logic               underflow
);

    localparam logic [ADDRBIT:0]   DEPTH_C  = FIFO_DEPTH[ADDRBIT:0];
    localparam logic [ADDRBIT:0]   AFULL_C  = AFULL_THRESH[ADDRBIT:0];
    localparam logic [ADDRBIT:0]   AEMPTY_C = AEMPTY_THRESH[ADDRBIT:0];
    localparam logic [ADDRBIT-1:0] PTR_INC  = {{(ADDRBIT-1){1'b0}}, 1'b1};
    localparam logic [ADDRBIT:0]   CNT_INC  = {{ADDRBIT{1'b0}}, 1'b1};

    logic [ADDRBIT-1:0] wr_ptr;
    logic [ADDRBIT-1:0] rd_ptr;
    logic [ADDRBIT:0]   count_q;
    logic               rd_valid_q;
    logic               overflow_q;
    logic               underflow_q;

    logic               full_w;
    logic               notempty_w;
    logic               push_legal;
    logic               pop_legal;
    logic               overflow_set;
    logic               underflow_set;
    logic [1:0]         gnt;

    assign full_w     = (count_q == DEPTH_C);
    assign notempty_w = (count_q != '0);

    // rst gates the requests so an asserted reset kills a pending grant at once,
    // before the asynchronous clear has even propagated through the state.
    assign push_legal = fifo_en & push_req & ~full_w     & ~flush & ~rst;
    assign pop_legal  = fifo_en & pop_req  & notempty_w  & ~flush & ~rst;

    assign overflow_set  = fifo_en & push_req & full_w;
    assign underflow_set = fifo_en & pop_req  & ~notempty_w;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({pop_legal, push_legal}),
        .gnt (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            // Error flags are deliberately left alone across a flush.
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (gnt[0]) begin
                wr_ptr  <= wr_ptr + PTR_INC;
                count_q <= count_q + CNT_INC;
            end else if (gnt[1]) begin
                rd_ptr  <= rd_ptr + PTR_INC;
                count_q <= count_q - CNT_INC;
            end
            rd_valid_q <= gnt[1];

            // A new error event in the same cycle as clr_err keeps the flag set.
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end else if (clr_err) begin
                overflow_q <= 1'b0;
            end
            if (underflow_set) begin
                underflow_q <= 1'b1;
            end else if (clr_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    // Occupancy is bounded and its low bits always equal the pointer distance;
    // a full FIFO shows up as equal pointers with count == depth.
    assert property (@(posedge clk) disable iff (rst)
        (count_q <= DEPTH_C) && (count_q[ADDRBIT-1:0] == (wr_ptr - rd_ptr)));

    assign write_en     = gnt[0];
    assign read_en      = gnt[1];
    assign push_ack     = gnt[0];
    assign pop_ack      = gnt[1];
    assign wraddr       = wr_ptr;
    assign rdaddr       = rd_ptr;
    assign fifofull     = full_w;
    assign notempty     = notempty_w;
    assign count        = count_q;
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign rd_valid     = rd_valid_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// tb/tb_fifo_access_ctrl.sv - self-checking bench for fifo_access_ctrl
module tb_fifo_access_ctrl;

    logic       clk;
    logic       rst;
    logic       fifo_en;
    logic       flush;
    logic       push_req;
    logic       pop_req;
    logic       clr_err;
    logic       push_ack;
    logic       pop_ack;
    logic       write_en;
    logic       read_en;
    logic [4:0] wraddr;
    logic [4:0] rdaddr;
    logic       fifofull;
    logic       notempty;
    logic [5:0] count;
    logic       almost_full;
    logic       almost_empty;
    logic       rd_valid;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard of memory addresses written and not yet read, oldest first.
    logic [4:0] addr_q[$];
    logic [4:0] exp_addr;

    fifo_access_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_en      (fifo_en),
        .flush        (flush),
        .push_req     (push_req),
        .pop_req      (pop_req),
        .clr_err      (clr_err),
        .push_ack     (push_ack),
        .pop_ack      (pop_ack),
        .write_en     (write_en),
        .read_en      (read_en),
        .wraddr       (wraddr),
        .rdaddr       (rdaddr),
        .fifofull     (fifofull),
        .notempty     (notempty),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .rd_valid     (rd_valid),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; fifo_en = 1'b1; flush = 1'b0;
        push_req = 1'b0; pop_req = 1'b0; clr_err = 1'b0;
        addr_q.delete();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; fifo_en = 1'b0; flush = 1'b0;
        push_req = 1'b0; pop_req = 1'b0; clr_err = 1'b0;
        tick();
        n_checks++;
        if (count !== 6'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", count);
        end
        n_checks++;
        if ({fifofull, notempty, almost_empty, almost_full} !== 4'b0010) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0010", {fifofull, notempty, almost_empty, almost_full});
        end
        n_checks++;
        if ({rd_valid, overflow, underflow, push_ack, pop_ack} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_status: got %b want 00000", {rd_valid, overflow, underflow, push_ack, pop_ack});
        end
        n_checks++;
        if ({wraddr, rdaddr} !== 10'd0) begin
            n_fail++; $display("FAIL reset_ptrs: got wr=%0d rd=%0d want 0/0", wraddr, rdaddr);
        end
        rst = 1'b0;
        fifo_en = 1'b1;
        tick();
    endtask

    task automatic test_push_pop3();
        push_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (push_ack !== 1'b1 || write_en !== 1'b1 || wraddr !== 5'(i)) begin
                n_fail++; $display("FAIL pp3_push%0d: got ack=%b we=%b wraddr=%0d want 1/1/%0d", i, push_ack, write_en, wraddr, i);
            end
            addr_q.push_back(5'(i));
            tick();
        end
        push_req = 1'b0;
        pop_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_addr = addr_q.pop_front();
            n_checks++;
            if (pop_ack !== 1'b1 || read_en !== 1'b1 || rdaddr !== exp_addr) begin
                n_fail++; $display("FAIL pp3_pop%0d: got ack=%b re=%b rdaddr=%0d want 1/1/%0d", i, pop_ack, read_en, rdaddr, exp_addr);
            end
            n_checks++;
            if (rd_valid !== (i > 0) || notempty !== 1'b1) begin
                n_fail++; $display("FAIL pp3_valid%0d: got rd_valid=%b notempty=%b want %b/1", i, rd_valid, notempty, i > 0);
            end
            tick();
        end
        pop_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b1 || notempty !== 1'b0 || pop_ack !== 1'b0) begin
            n_fail++; $display("FAIL pp3_last: got rd_valid=%b notempty=%b ack=%b want 1/0/0", rd_valid, notempty, pop_ack);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b0 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL pp3_idle: got rd_valid=%b underflow=%b want 0/0", rd_valid, underflow);
        end
        tick();
    endtask

    task automatic test_fill();
        push_req = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            n_checks++;
            if (push_ack !== 1'b1 || write_en !== 1'b1 || pop_ack !== 1'b0 || wraddr !== 5'(i)) begin
                n_fail++; $display("FAIL fill_push%0d: got ack=%b we=%b wraddr=%0d want 1/1/%0d", i, push_ack, write_en, wraddr, i);
            end
            n_checks++;
            if (count !== 6'(i) || almost_full !== (i >= 28) || almost_empty !== (i <= 4) || fifofull !== 1'b0) begin
                n_fail++; $display("FAIL fill_flags%0d: got count=%0d af=%b ae=%b full=%b", i, count, almost_full, almost_empty, fifofull);
            end
            addr_q.push_back(5'(i));
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (count !== 6'd32 || fifofull !== 1'b1 || almost_full !== 1'b1 || notempty !== 1'b1) begin
            n_fail++; $display("FAIL fill_full: got count=%0d full=%b af=%b want 32/1/1", count, fifofull, almost_full);
        end
        n_checks++;
        if (push_ack !== 1'b0 || write_en !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL fill_33rd: got ack=%b we=%b ovf=%b want 0/0/0", push_ack, write_en, overflow);
        end
        tick();
        push_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (overflow !== 1'b1 || count !== 6'd32) begin
            n_fail++; $display("FAIL fill_overflow: got ovf=%b count=%0d want 1/32", overflow, count);
        end
        tick();
    endtask

    task automatic test_full_both();
        logic [4:0] exp_wr;
        exp_wr   = 5'd0;
        push_req = 1'b1;
        pop_req  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                exp_addr = addr_q.pop_front();
                n_checks++;
                if (pop_ack !== 1'b1 || push_ack !== 1'b0 || rdaddr !== exp_addr || count !== 6'd32) begin
                    n_fail++; $display("FAIL both_pop%0d: got pop=%b push=%b rdaddr=%0d count=%0d want 1/0/%0d/32", k, pop_ack, push_ack, rdaddr, count, exp_addr);
                end
            end else begin
                n_checks++;
                if (push_ack !== 1'b1 || pop_ack !== 1'b0 || wraddr !== exp_wr || count !== 6'd31) begin
                    n_fail++; $display("FAIL both_push%0d: got push=%b pop=%b wraddr=%0d count=%0d want 1/0/%0d/31", k, push_ack, pop_ack, wraddr, count, exp_wr);
                end
                addr_q.push_back(exp_wr);
                exp_wr = exp_wr + 5'd1;
            end
            n_checks++;
            if (rd_valid !== (k % 2 == 1)) begin
                n_fail++; $display("FAIL both_rdv%0d: got %b want %b", k, rd_valid, k % 2 == 1);
            end
            tick();
        end
        push_req = 1'b0;
    endtask

    task automatic test_drain();
        pop_req = 1'b1;
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            exp_addr = addr_q.pop_front();
            n_checks++;
            if (pop_ack !== 1'b1 || rdaddr !== exp_addr || count !== 6'(32 - j)) begin
                n_fail++; $display("FAIL drain_pop%0d: got ack=%b rdaddr=%0d count=%0d want 1/%0d/%0d", j, pop_ack, rdaddr, count, exp_addr, 32 - j);
            end
            n_checks++;
            if (rd_valid !== (j > 0)) begin
                n_fail++; $display("FAIL drain_rdv%0d: got %b want %b", j, rd_valid, j > 0);
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (pop_ack !== 1'b0 || read_en !== 1'b0 || notempty !== 1'b0 || count !== 6'd0 || rd_valid !== 1'b1) begin
            n_fail++; $display("FAIL drain_empty: got ack=%b re=%b ne=%b count=%0d rdv=%b want 0/0/0/0/1", pop_ack, read_en, notempty, count, rd_valid);
        end
        tick();
        pop_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (underflow !== 1'b1 || rd_valid !== 1'b0 || almost_empty !== 1'b1) begin
            n_fail++; $display("FAIL drain_underflow: got unf=%b rdv=%b ae=%b want 1/0/1", underflow, rd_valid, almost_empty);
        end
        tick();
    endtask

    task automatic test_errors();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({overflow, underflow} !== 2'b00) begin
            n_fail++; $display("FAIL err_clear: got ovf/unf=%b want 00", {overflow, underflow});
        end
        tick();
        clr_err = 1'b1;
        pop_req = 1'b1;
        tick();
        clr_err = 1'b0;
        pop_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({overflow, underflow} !== 2'b01) begin
            n_fail++; $display("FAIL err_set_wins: got ovf/unf=%b want 01", {overflow, underflow});
        end
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_disable();
        fifo_en  = 1'b0;
        push_req = 1'b1;
        pop_req  = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({push_ack, pop_ack, write_en, read_en} !== 4'b0000) begin
            n_fail++; $display("FAIL dis_acks: got %b want 0000", {push_ack, pop_ack, write_en, read_en});
        end
        tick();
        push_req = 1'b0;
        pop_req  = 1'b0;
        fifo_en  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (count !== 6'd0 || underflow !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL dis_state: got count=%0d unf=%b ovf=%b want 0/0/0", count, underflow, overflow);
        end
        tick();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 40; i++) begin
            push_req = 1'b1;
            pop_req  = 1'b0;
            @(negedge clk);
            n_checks++;
            if (push_ack !== 1'b1 || wraddr !== 5'(i % 32) || count !== 6'd0) begin
                n_fail++; $display("FAIL wrap_push%0d: got ack=%b wraddr=%0d count=%0d want 1/%0d/0", i, push_ack, wraddr, count, i % 32);
            end
            addr_q.push_back(5'(i % 32));
            tick();
            push_req = 1'b0;
            pop_req  = 1'b1;
            @(negedge clk);
            exp_addr = addr_q.pop_front();
            n_checks++;
            if (pop_ack !== 1'b1 || rdaddr !== exp_addr || count !== 6'd1) begin
                n_fail++; $display("FAIL wrap_pop%0d: got ack=%b rdaddr=%0d count=%0d want 1/%0d/1", i, pop_ack, rdaddr, count, exp_addr);
            end
            tick();
        end
        pop_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (count !== 6'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL wrap_end: got count=%0d ovf=%b unf=%b want 0/0/0", count, overflow, underflow);
        end
        tick();
    endtask

    task automatic test_flush();
        push_req = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            addr_q.push_back(wraddr);
            tick();
        end
        push_req = 1'b0;
        pop_req  = 1'b1;
        @(negedge clk);
        exp_addr = addr_q.pop_front();
        n_checks++;
        if (pop_ack !== 1'b1 || rdaddr !== exp_addr) begin
            n_fail++; $display("FAIL flush_prepop: got ack=%b rdaddr=%0d want 1/%0d", pop_ack, rdaddr, exp_addr);
        end
        tick();
        pop_req  = 1'b0;
        push_req = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        n_checks++;
        if (count !== 6'd10 || rd_valid !== 1'b1 || push_ack !== 1'b0 || write_en !== 1'b0) begin
            n_fail++; $display("FAIL flush_cycle: got count=%0d rdv=%b ack=%b we=%b want 10/1/0/0", count, rd_valid, push_ack, write_en);
        end
        tick();
        flush    = 1'b0;
        push_req = 1'b0;
        addr_q.delete();
        @(negedge clk);
        n_checks++;
        if (count !== 6'd0 || wraddr !== 5'd0 || rdaddr !== 5'd0 || rd_valid !== 1'b0 || notempty !== 1'b0) begin
            n_fail++; $display("FAIL flush_after: got count=%0d wr=%0d rd=%0d rdv=%b ne=%b want 0/0/0/0/0", count, wraddr, rdaddr, rd_valid, notempty);
        end
        n_checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL flush_errs: got ovf=%b unf=%b want 0/0", overflow, underflow);
        end
        tick();
    endtask

    task automatic test_reset_mid_pop();
        push_req = 1'b1;
        repeat (2) tick();
        push_req = 1'b0;
        pop_req  = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b1 || pop_ack !== 1'b1 || count !== 6'd1) begin
            n_fail++; $display("FAIL rstpop_pre: got rdv=%b ack=%b count=%0d want 1/1/1", rd_valid, pop_ack, count);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (rd_valid !== 1'b0 || pop_ack !== 1'b0 || read_en !== 1'b0 || count !== 6'd0) begin
            n_fail++; $display("FAIL rstpop_async: got rdv=%b ack=%b re=%b count=%0d want 0/0/0/0", rd_valid, pop_ack, read_en, count);
        end
        tick();
        rst     = 1'b0;
        pop_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b0 || count !== 6'd0 || rdaddr !== 5'd0) begin
            n_fail++; $display("FAIL rstpop_after: got rdv=%b count=%0d rdaddr=%0d want 0/0/0", rd_valid, count, rdaddr);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; fifo_en = 1'b0; flush = 1'b0;
        push_req = 1'b0; pop_req = 1'b0; clr_err = 1'b0;
        test_reset();
        test_push_pop3();
        do_reset();
        test_fill();
        test_full_both();
        test_drain();
        test_errors();
        test_disable();
        do_reset();
        test_wrap();
        test_flush();
        test_reset_mid_pop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
